// File: rtl/ifq.sv
// ---------------------------------------------------------------------------
// ifq -- instruction fetch queue
//
// Issues sequential word fetches to memory and buffers the returned words,
// each tagged with its fetch address, in a small FIFO. The CPU fetch stage
// drains the FIFO with a valid/ready handshake. A redirect flushes the queue,
// reloads the fetch PC and discards responses still owed for requests issued
// before the redirect.
//
// Parameters
//   DEPTH      queue entries (power of two, 2..16)
//   RESET_PC   first fetch address after reset
//   MAX_OUTST  maximum granted-but-unanswered memory requests
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active low
//   mem_req      out  fetch request valid
//   mem_addr     out  fetch word address (bits [1:0] always 0)
//   mem_gnt      in   request accepted this cycle
//   mem_rvalid   in   response valid (responses return in request order)
//   mem_rdata    in   instruction word
//   instr_valid  out  queue head valid
//   instr        out  head instruction
//   instr_pc     out  address of the head instruction
//   instr_ready  in   consumer accepts the head this cycle
//   redirect     in   flush and refetch from redirect_pc
//   redirect_pc  in   new fetch address (bits [1:0] ignored)
//
// Configuration
//   IFQ_BYPASS_EN  when defined, a response arriving while the queue is empty
//                  (and no stale responses are being drained) is presented on
//                  instr/instr_valid in the same cycle.
// ---------------------------------------------------------------------------
module ifq #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int OW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST + 1) : 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [31:0]   fpc;
  logic [CW-1:0] count, count_nxt;
  logic [OW-1:0] outst, outst_nxt;
  logic [OW-1:0] drop, drop_nxt;
  logic [AW-1:0] head, tail;

  logic [31:0]   q_data [DEPTH];
  logic [31:0]   q_pc   [DEPTH];

  logic          grant;
  logic          rsp;
  logic          push;
  logic          pop;
  logic          q_empty;
  logic [31:0]   rsp_pc;

  // Room for one more request: every queued word plus every word still owed
  // by memory must fit in the queue, and the outstanding limit must allow it.
  function automatic logic cap_ok(input logic [CW-1:0] c, input logic [OW-1:0] o);
    return ((32'(c) + 32'(o)) < 32'(DEPTH)) && (32'(o) < 32'(MAX_OUTST));
  endfunction

  assign grant   = mem_req & mem_gnt;
  // A response with nothing outstanding cannot belong to any request; ignore it
  // so the counters can never underflow.
  assign rsp     = mem_rvalid & (outst != '0);
  assign q_empty = (count == '0);

  // Outside DRAIN every outstanding request belongs to the current sequential
  // stream ending just below fpc, and memory answers in order, so the oldest
  // one (the one being answered now) sits outst words below fpc.
  assign rsp_pc  = fpc - (32'(outst) << 2);

  // mem_req is gated by the reset level so it stays low while reset is held.
  assign mem_req  = rst & (state == S_FETCH) & cap_ok(count, outst) & ~redirect;
  assign mem_addr = fpc;

`ifdef IFQ_BYPASS_EN
  logic bypass;

  // An empty queue forwards the arriving word directly; it is only written
  // into the queue if the consumer does not take it in the same cycle.
  always_comb begin
    bypass      = q_empty & (state != S_DRAIN) & rsp;
    instr_valid = ~redirect & (~q_empty | bypass);
    instr       = q_empty ? mem_rdata : q_data[head];
    instr_pc    = q_empty ? rsp_pc    : q_pc[head];
    push        = rsp & (state != S_DRAIN) & ~redirect & ~(bypass & instr_ready);
    pop         = instr_valid & instr_ready & ~q_empty;
  end
`else
  always_comb begin
    instr_valid = ~redirect & ~q_empty;
    instr       = q_data[head];
    instr_pc    = q_pc[head];
    push        = rsp & (state != S_DRAIN) & ~redirect;
    pop         = instr_valid & instr_ready;
  end
`endif

  // Occupancy and outstanding-request bookkeeping. A redirect empties the
  // queue outright; grants and responses are still counted that cycle.
  always_comb begin
    count_nxt = count;
    if (redirect) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end

    outst_nxt = outst;
    case ({grant, rsp})
      2'b10:   outst_nxt = outst + 1'b1;
      2'b01:   outst_nxt = outst - 1'b1;
      default: outst_nxt = outst;
    endcase
  end

  // drop is loaded with the number of responses still owed after this cycle,
  // so a response arriving together with the redirect is already accounted
  // for. A redirect while draining reloads it the same way, which keeps the
  // existing drops counting.
  always_comb begin
    drop_nxt = drop;
    if (redirect) begin
      drop_nxt = outst_nxt;
    end else if ((state == S_DRAIN) && rsp && (drop != '0)) begin
      drop_nxt = drop - 1'b1;
    end
  end

  // FETCH/STALL are chosen from next-cycle occupancy so that FETCH always
  // means a request may be issued; STALL->FETCH therefore costs no bubble.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      if (drop_nxt != '0) state_nxt = S_DRAIN;
      else                state_nxt = cap_ok(count_nxt, outst_nxt) ? S_FETCH : S_STALL;
    end else begin
      case (state)
        S_DRAIN: begin
          if (drop_nxt == '0)
            state_nxt = cap_ok(count_nxt, outst_nxt) ? S_FETCH : S_STALL;
        end
        S_FETCH, S_STALL: begin
          state_nxt = cap_ok(count_nxt, outst_nxt) ? S_FETCH : S_STALL;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_FETCH;
      count <= '0;
      outst <= '0;
      drop  <= '0;
      fpc   <= RESET_PC & 32'hFFFF_FFFC;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      outst <= outst_nxt;
      drop  <= drop_nxt;
      if (redirect)
        fpc <= redirect_pc & 32'hFFFF_FFFC;
      else if (grant)
        fpc <= fpc + 32'd4;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (redirect) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
    end
  end

  // Storage carries no reset; entries are only read once count covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= mem_rdata;
      q_pc[tail]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifq.sv
// ---------------------------------------------------------------------------
// tb_ifq -- randomized scoreboard bench for ifq
//
// A stimulus process plays the memory (in-order responses to granted
// requests) and the consumer, and issues random redirects in phases. A
// monitor on the falling edge tracks the fetch stream by address and epoch,
// pushes the words the CPU should see into a scoreboard queue, and compares
// every accepted head, the request gating and the request addresses.
// ---------------------------------------------------------------------------
module tb_ifq;

  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  ifq #(
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    int          cycles;
    int          p_gnt;
    int          p_rv;
    int          p_rdy;
    int          p_redir;
    bit          fin_redir;
    logic [31:0] fin_pc;
  } phase_t;

  req_t        inflight[$];
  exp_t        exp_q[$];
  phase_t      phases[$];

  int          checks;
  int          errors;
  int          cur_epoch;
  logic [31:0] exp_fpc;
  bit          mon_en;

  logic        m_grant;
  logic        m_allowed;
  logic        m_exp_valid;
  int          m_stale;
  logic        prev_req;
  logic        prev_gnt;
  logic [31:0] prev_addr;
  req_t        m_rsp;
  exp_t        m_head;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sampled mid-cycle, describes the transaction at the next edge.
  always @(negedge clk) begin
    if (mon_en) begin
      m_grant = mem_req & mem_gnt;

      m_stale = 0;
      foreach (inflight[i]) if (inflight[i].epoch != cur_epoch) m_stale++;

      m_allowed = !redirect && (m_stale == 0) &&
                  ((exp_q.size() + inflight.size()) < DEPTH) &&
                  (inflight.size() < MAX_OUTST);
      check_output("mem_req", {31'd0, mem_req}, {31'd0, m_allowed});
      if (mem_req) check_output("mem_addr", mem_addr, exp_fpc);

      if (prev_req && !prev_gnt && !redirect) begin
        check_output("req_hold", {31'd0, mem_req}, 32'd1);
        check_output("addr_hold", mem_addr, prev_addr);
      end

`ifdef IFQ_BYPASS_EN
      m_exp_valid = !redirect && ((exp_q.size() > 0) ||
                    (mem_rvalid && (inflight.size() > 0) && (inflight[0].epoch == cur_epoch)));
`else
      m_exp_valid = !redirect && (exp_q.size() > 0);
`endif
      check_output("instr_valid", {31'd0, instr_valid}, {31'd0, m_exp_valid});

      if (mem_rvalid && (inflight.size() > 0)) begin
        m_rsp = inflight.pop_front();
        if (!redirect && (m_rsp.epoch == cur_epoch))
          exp_q.push_back('{pc: m_rsp.addr, data: mem_word(m_rsp.addr)});
      end

      if (instr_valid && instr_ready) begin
        check_output("pop_has_entry", {31'd0, (exp_q.size() != 0)}, 32'd1);
        if (exp_q.size() != 0) begin
          m_head = exp_q.pop_front();
          check_output("instr_pc", instr_pc, m_head.pc);
          check_output("instr", instr, m_head.data);
        end
      end

      if (m_grant) begin
        inflight.push_back('{addr: exp_fpc, epoch: cur_epoch});
        exp_fpc = exp_fpc + 32'd4;
      end

      if (redirect) begin
        exp_q.delete();
        cur_epoch++;
        exp_fpc = redirect_pc & 32'hFFFF_FFFC;
      end

      prev_req  = mem_req;
      prev_gnt  = mem_gnt;
      prev_addr = mem_addr;
    end
  end

  // Drive one cycle of memory/consumer/redirect behaviour.
  task automatic apply_stimulus(input phase_t p, input bit force_redir);
    @(posedge clk);
    #1;
    mem_gnt     = ($urandom_range(99) < p.p_gnt);
    mem_rvalid  = (inflight.size() > 0) && ($urandom_range(99) < p.p_rv);
    mem_rdata   = mem_rvalid ? mem_word(inflight[0].addr) : $urandom();
    instr_ready = ($urandom_range(99) < p.p_rdy);
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = p.fin_pc;
    end else begin
      redirect    = ($urandom_range(99) < p.p_redir);
      redirect_pc = ($urandom_range(99) < 20) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                              : $urandom();
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cur_epoch   = 0;
    exp_fpc     = RESET_PC;
    mon_en      = 1'b0;
    prev_req    = 1'b0;
    prev_gnt    = 1'b0;
    prev_addr   = '0;
    rst         = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    phases.push_back('{40,  100, 100, 100, 0,  1'b0, 32'h0});
    phases.push_back('{30,  100, 100, 0,   0,  1'b0, 32'h0});
    phases.push_back('{3,   100, 100, 100, 0,  1'b0, 32'h0});
    phases.push_back('{3,   100, 0,   100, 0,  1'b1, 32'h0000_4001});
    phases.push_back('{20,  100, 100, 100, 0,  1'b0, 32'h0});
    phases.push_back('{4,   100, 100, 100, 0,  1'b1, 32'hFFFF_FFF4});
    phases.push_back('{20,  100, 100, 100, 0,  1'b0, 32'h0});
    phases.push_back('{300, 70,  60,  70,  3,  1'b0, 32'h0});
    phases.push_back('{200, 50,  30,  40,  6,  1'b0, 32'h0});
    phases.push_back('{200, 90,  90,  90,  10, 1'b0, 32'h0});
    phases.push_back('{150, 100, 25,  100, 2,  1'b0, 32'h0});
    phases.push_back('{100, 80,  80,  20,  0,  1'b0, 32'h0});

    repeat (3) begin
      @(negedge clk);
      check_output("reset_mem_req", {31'd0, mem_req}, 32'd0);
      check_output("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
      check_output("reset_mem_addr", mem_addr, RESET_PC);
    end

    @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    foreach (phases[k]) begin
      for (int c = 0; c < phases[k].cycles; c++) apply_stimulus(phases[k], 1'b0);
      if (phases[k].fin_redir) apply_stimulus(phases[k], 1'b1);
    end

    @(posedge clk);
    #1;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    @(negedge clk);
    #1;
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
